// File: rtl/eth_pkg.sv
// rtl/eth_pkg.sv - shared state type, payload limits and framing constants for the Ethernet path
package eth_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_STREAM,
        ST_PAD,
        ST_WAIT_DONE,
        ST_GAP
    } sched_state_t;

    localparam int CNT_W = 11;

    localparam int DEF_MAX_PAYLOAD = 1500;
    localparam int DEF_MIN_PAYLOAD = 46;
    localparam int DEF_IFG_CYCLES  = 48;
    localparam logic [7:0] DEF_PAD_BYTE = 8'h00;

    // Framing constants the packager prepends ahead of the payload.
    localparam logic [7:0] PREAMBLE_BYTE = 8'h55;
    localparam int         PREAMBLE_LEN  = 7;
    localparam logic [7:0] SFD_BYTE      = 8'hD5;

endpackage

// File: rtl/eth_frame_scheduler_rr_arbiter_2.sv
// rtl/eth_frame_scheduler_rr_arbiter_2.sv - 2-way round-robin arbiter, pointer updated on grant
module rr_arbiter_2 (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [1:0] req,
    input  logic       update,
    output logic       gnt
);

    // Index of the last granted source; resetting to 1 makes s0 win the first tie.
    logic last;

    always_comb begin
        gnt = req[1];
        if (req == 2'b11) begin
            gnt = ~last;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            last <= 1'b1;
        end else if (update) begin
            last <= gnt;
        end
    end

endmodule

// File: rtl/eth_frame_scheduler.sv
// rtl/eth_frame_scheduler.sv - two-source frame scheduler for the packager; FRAME_SCHED_PAD_EN adds short-frame padding
module eth_frame_scheduler
    import eth_pkg::*;
#(
    parameter int MAX_PAYLOAD = DEF_MAX_PAYLOAD,
    parameter int IFG_CYCLES  = DEF_IFG_CYCLES
`ifdef FRAME_SCHED_PAD_EN
    ,
    parameter int         MIN_PAYLOAD = DEF_MIN_PAYLOAD,
    parameter logic [7:0] PAD_BYTE    = DEF_PAD_BYTE
`endif
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        s0_valid,
    input  logic [7:0]  s0_data,
    input  logic        s0_last,
    output logic        s0_ready,
    input  logic        s1_valid,
    input  logic [7:0]  s1_data,
    input  logic        s1_last,
    output logic        s1_ready,
    output logic        pkt_valid,
    output logic [7:0]  pkt_byte,
    input  logic        pkt_done,
    output logic        busy,
    output logic        grant,
    output logic [15:0] frames_sent
);

    sched_state_t     state, state_nxt;
    logic [CNT_W-1:0] byte_cnt;
    logic [CNT_W-1:0] cnt_inc;
    logic [CNT_W-1:0] gap_cnt;
    logic             cont;
    logic             arb_gnt;
    logic             arb_take;
    logic             xfer;
    logic             xfer_last;
    logic [7:0]       xfer_data;
    logic             at_max;

    rr_arbiter_2 u_arb (
        .clk    (clk),
        .rst_n  (rst_n),
        .req    ({s1_valid, s0_valid}),
        .update (arb_take),
        .gnt    (arb_gnt)
    );

    assign cnt_inc   = byte_cnt + 11'd1;
    assign at_max    = (cnt_inc == CNT_W'(MAX_PAYLOAD));
    assign xfer_data = grant ? s1_data : s0_data;
    assign xfer_last = grant ? s1_last : s0_last;

    // Readies come from registered state and grant only, never from valid.
    assign s0_ready = (state == ST_STREAM) && !grant;
    assign s1_ready = (state == ST_STREAM) &&  grant;
    assign xfer     = grant ? (s1_valid && s1_ready) : (s0_valid && s0_ready);
    assign busy     = (state != ST_IDLE);

    always_comb begin
        state_nxt = state;
        arb_take  = 1'b0;
        case (state)
            ST_IDLE: begin
                if (cont) begin
                    state_nxt = ST_STREAM;
                end else if (s0_valid || s1_valid) begin
                    arb_take  = 1'b1;
                    state_nxt = ST_STREAM;
                end
            end
            ST_STREAM: begin
                if (xfer) begin
                    if (xfer_last) begin
`ifdef FRAME_SCHED_PAD_EN
                        if (cnt_inc < CNT_W'(MIN_PAYLOAD)) begin
                            state_nxt = ST_PAD;
                        end else begin
                            state_nxt = ST_WAIT_DONE;
                        end
`else
                        state_nxt = ST_WAIT_DONE;
`endif
                    end else if (at_max) begin
                        state_nxt = ST_WAIT_DONE;
                    end
                end
            end
`ifdef FRAME_SCHED_PAD_EN
            ST_PAD: begin
                if (cnt_inc == CNT_W'(MIN_PAYLOAD)) begin
                    state_nxt = ST_WAIT_DONE;
                end
            end
`endif
            ST_WAIT_DONE: begin
                if (pkt_done) begin
                    state_nxt = ST_GAP;
                end
            end
            ST_GAP: begin
                if (gap_cnt == '0) begin
                    state_nxt = ST_IDLE;
                end
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= ST_IDLE;
            byte_cnt    <= '0;
            gap_cnt     <= '0;
            cont        <= 1'b0;
            grant       <= 1'b0;
            pkt_valid   <= 1'b0;
            pkt_byte    <= 8'h00;
            frames_sent <= 16'h0000;
        end else begin
            state     <= state_nxt;
            pkt_valid <= 1'b0;
            case (state)
                ST_IDLE: begin
                    byte_cnt <= '0;
                    if (arb_take) begin
                        grant <= arb_gnt;
                    end
                end
                ST_STREAM: begin
                    if (xfer) begin
                        byte_cnt  <= cnt_inc;
                        pkt_valid <= 1'b1;
                        pkt_byte  <= xfer_data;
                        // cont carries ownership into the next frame of a split message.
                        if (xfer_last) begin
                            cont <= 1'b0;
                        end else if (at_max) begin
                            cont <= 1'b1;
                        end
                    end
                end
`ifdef FRAME_SCHED_PAD_EN
                ST_PAD: begin
                    byte_cnt  <= cnt_inc;
                    pkt_valid <= 1'b1;
                    pkt_byte  <= PAD_BYTE;
                end
`endif
                ST_WAIT_DONE: begin
                    if (pkt_done) begin
                        frames_sent <= frames_sent + 16'd1;
                        gap_cnt     <= CNT_W'(IFG_CYCLES - 1);
                    end
                end
                ST_GAP: begin
                    if (gap_cnt != '0) begin
                        gap_cnt <= gap_cnt - 11'd1;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_eth_frame_scheduler.sv
// tb/tb_eth_frame_scheduler.sv - directed self-checking bench for eth_frame_scheduler
module tb_eth_frame_scheduler;

    logic        clk;
    logic        rst_n;
    logic        s0_valid, s0_last, s0_ready;
    logic [7:0]  s0_data;
    logic        s1_valid, s1_last, s1_ready;
    logic [7:0]  s1_data;
    logic        pkt_valid;
    logic [7:0]  pkt_byte;
    logic        pkt_done;
    logic        busy;
    logic        grant;
    logic [15:0] frames_sent;

    int checks = 0;
    int errors = 0;
    int cap_n = 0;
    int viol_cnt = 0;
    logic [7:0] cap_mem [0:8191];
    logic       gnt_rec [0:7];
    int         len_rec [0:7];
    bit         abort = 0;

    eth_frame_scheduler dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .s0_valid    (s0_valid),
        .s0_data     (s0_data),
        .s0_last     (s0_last),
        .s0_ready    (s0_ready),
        .s1_valid    (s1_valid),
        .s1_data     (s1_data),
        .s1_last     (s1_last),
        .s1_ready    (s1_ready),
        .pkt_valid   (pkt_valid),
        .pkt_byte    (pkt_byte),
        .pkt_done    (pkt_done),
        .busy        (busy),
        .grant       (grant),
        .frames_sent (frames_sent)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (pkt_valid && cap_n < 8192) begin
            cap_mem[cap_n] <= pkt_byte;
            cap_n <= cap_n + 1;
        end
        if ((s0_ready && grant) || (s1_ready && !grant) || (s0_ready && s1_ready))
            viol_cnt <= viol_cnt + 1;
    end

    task automatic drive(input int src, input logic v, input logic [7:0] d, input logic l);
        if (src == 0) begin
            s0_valid = v; s0_data = d; s0_last = l;
        end else begin
            s1_valid = v; s1_data = d; s1_last = l;
        end
    endtask

    task automatic apply_reset();
        rst_n = 1'b0;
        pkt_done = 1'b0;
        drive(0, 1'b0, 8'h00, 1'b0);
        drive(1, 1'b0, 8'h00, 1'b0);
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        #1;
    endtask

    // Sends nmsg messages of mlen bytes back to back with valid held high; byte i is base+i.
    task automatic send_stream(input int src, input int nmsg, input int mlen, input logic [7:0] base);
        int  total;
        bit  ok;
        total = nmsg * mlen;
        for (int i = 0; i < total; i++) begin
            drive(src, 1'b1, base + 8'(i), (i % mlen) == mlen - 1);
            ok = 0;
            for (int t = 0; t < 20000; t++) begin
                @(negedge clk);
                if (abort) break;
                if ((src == 0) ? s0_ready : s1_ready) begin
                    ok = 1;
                    break;
                end
            end
            if (!ok) begin
                if (!abort) begin
                    checks++;
                    errors++;
                    $display("FAIL send_timeout src=%0d byte=%0d ready never seen", src, i);
                end
                drive(src, 1'b0, 8'h00, 1'b0);
                return;
            end
            @(posedge clk);
            #1;
        end
        drive(src, 1'b0, 8'h00, 1'b0);
    endtask

    // Acts as the packager: pulses pkt_done once each frame's strobes have ended.
    task automatic responder(input int nframes);
        int len;
        int quiet;
        bit ok;
        for (int f = 0; f < nframes; f++) begin
            len = 0; quiet = 0; ok = 0;
            for (int t = 0; t < 20000; t++) begin
                @(negedge clk);
                if (pkt_valid) begin
                    if (len == 0) gnt_rec[f] = grant;
                    len++;
                    quiet = 0;
                end else if (len > 0) begin
                    quiet++;
                    if (quiet >= 3 && !s0_ready && !s1_ready) begin
                        ok = 1;
                        break;
                    end
                end
            end
            if (!ok) begin
                checks++;
                errors++;
                $display("FAIL responder_timeout frame=%0d strobes=%0d", f, len);
                return;
            end
            len_rec[f] = len;
            pkt_done = 1'b1;
            @(negedge clk);
            pkt_done = 1'b0;
        end
    endtask

    task automatic wait_frames(input int n);
        for (int t = 0; t < 500 && frames_sent != 16'(n); t++) @(negedge clk);
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        pkt_done = 1'b0;
        drive(0, 1'b0, 8'h00, 1'b0);
        drive(1, 1'b0, 8'h00, 1'b0);
        #2;
        checks++; if (pkt_valid !== 1'b0) begin errors++; $display("FAIL reset_pkt_valid got=%b exp=0", pkt_valid); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got=%b exp=0", busy); end
        checks++; if (grant !== 1'b0) begin errors++; $display("FAIL reset_grant got=%b exp=0", grant); end
        checks++; if (frames_sent !== 16'd0) begin errors++; $display("FAIL reset_frames got=%0d exp=0", frames_sent); end
        checks++; if ({s0_ready, s1_ready} !== 2'b00) begin errors++; $display("FAIL reset_ready got=%b exp=00", {s0_ready, s1_ready}); end
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL idle_busy got=%b exp=0", busy); end
    endtask

    task automatic test_single_frame();
        int base;
        int bad;
        logic busy48, busy49;
        apply_reset();
        base = cap_n;
        send_stream(0, 1, 100, 8'h01);
        @(negedge clk);
        checks++; if (s0_ready !== 1'b0) begin errors++; $display("FAIL single_ready_after_last got=%b exp=0", s0_ready); end
        checks++; if (busy !== 1'b1) begin errors++; $display("FAIL single_busy_wait got=%b exp=1", busy); end
        repeat (4) @(negedge clk);
        checks++; if (cap_n - base !== 100) begin errors++; $display("FAIL single_strobes got=%0d exp=100", cap_n - base); end
        bad = 0;
        for (int i = 0; i < 100; i++) if (cap_mem[base + i] !== 8'(8'h01 + i)) bad++;
        checks++; if (bad !== 0) begin errors++; $display("FAIL single_data bad_bytes=%0d exp=0", bad); end
        @(negedge clk);
        pkt_done = 1'b1;
        @(posedge clk);
        #1;
        pkt_done = 1'b0;
        busy48 = 1'b0; busy49 = 1'b1;
        for (int n = 1; n <= 49; n++) begin
            @(negedge clk);
            if (n == 48) busy48 = busy;
            if (n == 49) busy49 = busy;
        end
        checks++; if (frames_sent !== 16'd1) begin errors++; $display("FAIL single_frames got=%0d exp=1", frames_sent); end
        checks++; if (busy48 !== 1'b1) begin errors++; $display("FAIL single_busy_gap_end got=%b exp=1", busy48); end
        checks++; if (busy49 !== 1'b0) begin errors++; $display("FAIL single_busy_idle got=%b exp=0", busy49); end
    endtask

    task automatic test_round_robin();
        int base;
        int v0;
        int bad;
        logic [7:0] exp_b;
        apply_reset();
        base = cap_n;
        v0 = viol_cnt;
        fork
            send_stream(0, 2, 10, 8'h10);
            send_stream(1, 2, 10, 8'h80);
            responder(4);
        join
        wait_frames(4);
        checks++; if (frames_sent !== 16'd4) begin errors++; $display("FAIL rr_frames got=%0d exp=4", frames_sent); end
        checks++; if ({gnt_rec[0], gnt_rec[1], gnt_rec[2], gnt_rec[3]} !== 4'b0101)
            begin errors++; $display("FAIL rr_grant_seq got=%b%b%b%b exp=0101", gnt_rec[0], gnt_rec[1], gnt_rec[2], gnt_rec[3]); end
        checks++; if (viol_cnt - v0 !== 0) begin errors++; $display("FAIL rr_idle_ready got=%0d exp=0", viol_cnt - v0); end
        bad = 0;
        for (int i = 0; i < 40; i++) begin
            exp_b = ((i / 10) % 2 == 0) ? 8'(8'h10 + (i / 20) * 10 + i % 10) : 8'(8'h80 + (i / 20) * 10 + i % 10);
            if (cap_mem[base + i] !== exp_b) bad++;
        end
        checks++; if (bad !== 0 || cap_n - base !== 40) begin errors++; $display("FAIL rr_data bad_bytes=%0d strobes=%0d exp=0,40", bad, cap_n - base); end
    endtask

    task automatic test_split();
        int base;
        int bad;
        apply_reset();
        base = cap_n;
        fork
            send_stream(1, 1, 3200, 8'h00);
            begin
                repeat (20) @(negedge clk);
                send_stream(0, 1, 5, 8'hA0);
            end
            responder(4);
        join
        wait_frames(4);
        checks++; if (len_rec[0] !== 1500 || len_rec[1] !== 1500 || len_rec[2] !== 200 || len_rec[3] !== 5)
            begin errors++; $display("FAIL split_lengths got=%0d,%0d,%0d,%0d exp=1500,1500,200,5", len_rec[0], len_rec[1], len_rec[2], len_rec[3]); end
        checks++; if ({gnt_rec[0], gnt_rec[1], gnt_rec[2], gnt_rec[3]} !== 4'b1110)
            begin errors++; $display("FAIL split_grants got=%b%b%b%b exp=1110", gnt_rec[0], gnt_rec[1], gnt_rec[2], gnt_rec[3]); end
        bad = 0;
        for (int i = 0; i < 3200; i++) if (cap_mem[base + i] !== 8'(i)) bad++;
        for (int i = 0; i < 5; i++) if (cap_mem[base + 3200 + i] !== 8'(8'hA0 + i)) bad++;
        checks++; if (bad !== 0) begin errors++; $display("FAIL split_data bad_bytes=%0d exp=0", bad); end
    endtask

    task automatic test_pad();
        int base;
        int bad;
        int exp_n;
        apply_reset();
        base = cap_n;
        fork
            send_stream(0, 1, 10, 8'h30);
            responder(1);
        join
        wait_frames(1);
`ifdef FRAME_SCHED_PAD_EN
        exp_n = 46;
`else
        exp_n = 10;
`endif
        checks++; if (len_rec[0] !== exp_n) begin errors++; $display("FAIL pad_strobes got=%0d exp=%0d", len_rec[0], exp_n); end
        bad = 0;
        for (int i = 0; i < exp_n; i++)
            if (cap_mem[base + i] !== ((i < 10) ? 8'(8'h30 + i) : 8'h00)) bad++;
        checks++; if (bad !== 0) begin errors++; $display("FAIL pad_data bad_bytes=%0d exp=0", bad); end
    endtask

    task automatic test_spurious_done();
        int base;
        logic busy48, busy49, busy_mid;
        apply_reset();
        base = cap_n;
        fork
            send_stream(0, 1, 20, 8'h40);
            begin
                repeat (8) @(negedge clk);
                pkt_done = 1'b1;
                @(negedge clk);
                pkt_done = 1'b0;
            end
        join
        repeat (3) @(negedge clk);
        checks++; if (frames_sent !== 16'd0) begin errors++; $display("FAIL spur_stream_frames got=%0d exp=0", frames_sent); end
        checks++; if (cap_n - base !== 20) begin errors++; $display("FAIL spur_stream_strobes got=%0d exp=20", cap_n - base); end
        checks++; if (busy !== 1'b1) begin errors++; $display("FAIL spur_wait_busy got=%b exp=1", busy); end
        pkt_done = 1'b1;
        @(posedge clk);
        #1;
        pkt_done = 1'b0;
        busy48 = 1'b0; busy49 = 1'b1; busy_mid = 1'b0;
        for (int n = 1; n <= 49; n++) begin
            @(negedge clk);
            if (n == 10) pkt_done = 1'b1;
            if (n == 11) pkt_done = 1'b0;
            if (n == 20) busy_mid = busy;
            if (n == 48) busy48 = busy;
            if (n == 49) busy49 = busy;
        end
        checks++; if (frames_sent !== 16'd1) begin errors++; $display("FAIL spur_gap_frames got=%0d exp=1", frames_sent); end
        checks++; if ({busy_mid, busy48, busy49} !== 3'b110) begin errors++; $display("FAIL spur_gap_timing got=%b exp=110", {busy_mid, busy48, busy49}); end
    endtask

    task automatic test_reset_midframe();
        int base;
        int snap;
        int bad;
        apply_reset();
        base = cap_n;
        fork
            send_stream(1, 1, 100, 8'h60);
            begin
                for (int t = 0; t < 2000 && cap_n - base < 50; t++) @(negedge clk);
                #2;
                rst_n = 1'b0;
                #1;
                checks++; if ({pkt_valid, s1_ready, busy, grant} !== 4'b0000)
                    begin errors++; $display("FAIL midrst_outputs got=%b exp=0000", {pkt_valid, s1_ready, busy, grant}); end
                snap = cap_n;
                repeat (5) @(negedge clk);
                checks++; if (cap_n !== snap) begin errors++; $display("FAIL midrst_no_bytes got=%0d exp=%0d", cap_n, snap); end
                abort = 1;
            end
        join
        abort = 0;
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        #1;
        base = cap_n;
        fork
            send_stream(0, 1, 10, 8'hC0);
            send_stream(1, 1, 10, 8'hD0);
            responder(2);
        join
        wait_frames(2);
        checks++; if (gnt_rec[0] !== 1'b0 || gnt_rec[1] !== 1'b1)
            begin errors++; $display("FAIL midrst_priority got=%b%b exp=01", gnt_rec[0], gnt_rec[1]); end
        bad = 0;
        for (int i = 0; i < 10; i++) if (cap_mem[base + i] !== 8'(8'hC0 + i)) bad++;
        checks++; if (bad !== 0 || len_rec[0] !== 10) begin errors++; $display("FAIL midrst_new_frame bad_bytes=%0d len=%0d exp=0,10", bad, len_rec[0]); end
    endtask

    initial begin
        test_reset();
        test_single_frame();
        test_round_robin();
        test_split();
        test_pad();
        test_spurious_done();
        test_reset_midframe();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/eth_frame_scheduler.md
# eth_frame_scheduler

Frame-level controller in front of the Ethernet packager byte buffer. Arbitrates between two byte-stream requesters: s0 (encoder NAL payload) and s1 (control/status messages). Forwards one requester's bytes at a time as a single frame payload. Splits payloads longer than MAX_PAYLOAD, waits for the packager's end-of-transmission pulse, and enforces the inter-frame gap before the next frame.

## Interface
- MAX_PAYLOAD, 1500: maximum payload bytes per frame; longer streams are split.
- MIN_PAYLOAD, 46: minimum payload bytes; only used when padding is compiled in.
- IFG_CYCLES, 48: idle cycles after pkt_done, equal to 96 bit-times at one dibit/cycle.
- PAD_BYTE, 8'h00: fill value for padding.
- clk  in  1  single clock.
- rst_n  in  1  asynchronous, active-low reset.
- s0_valid / s1_valid  in  1  requester has a byte.
- s0_data / s1_data  in  8  requester byte.
- s0_last / s1_last  in  1  byte is the last of the requester's message.
- s0_ready / s1_ready  out  1  scheduler accepts the byte this cycle.
- pkt_valid  out  1  byte strobe to the packager buffer (its valid_in).
- pkt_byte  out  8  byte to the packager buffer (its byte_in).
- pkt_done  in  1  one-cycle pulse from the packager at end of transmission (its buffer_done).
- busy  out  1  high whenever state is not IDLE.
- grant  out  1  index of the current or most recent owner.
- frames_sent  out  16  count of completed frames; wraps.

## Operation
- States: IDLE, STREAM, PAD, WAIT_DONE, GAP.
- IDLE
  - If exactly one sN_valid is high, grant that source.
  - If both are high, grant round-robin: the source not granted last wins. After reset, s0 wins.
  - If cont is set, re-grant the same source with no arbitration.
  - Byte counter cleared. Go to STREAM.
- STREAM
  - Ready for the granted source is high. The other ready is low. Neither ready depends on valid.
  - Each valid&ready transfer increments the 11-bit counter.
  - Transfer with last: clear cont. Go to PAD or WAIT_DONE.
  - Transfer without last when the counter reaches MAX_PAYLOAD: set cont. Go to WAIT_DONE.
- PAD (FRAME_SCHED_PAD_EN only)
  - Emit PAD_BYTE once per cycle until the counter equals MIN_PAYLOAD, then go to WAIT_DONE.
  - Entered only if the counter is below MIN_PAYLOAD. Otherwise go straight to WAIT_DONE.
- WAIT_DONE
  - Both readys low.
  - On pkt_done: increment frames_sent, load the gap counter, go to GAP.
- GAP: count IFG_CYCLES cycles, then go to IDLE.
- pkt_done outside WAIT_DONE is ignored.
- Source valid during WAIT_DONE or GAP is held off by ready=0; no byte is lost.
- A source deasserting valid mid-message in STREAM is waited on indefinitely. There is no timeout.

## Timing
- Reset values: all outputs 0, state IDLE, round-robin pointer favours s0, cont=0.
- Reset mid-frame aborts immediately. The packager sees pkt_valid fall with no further bytes.
- sN_ready is decoded from registered state and grant only.
- pkt_valid and pkt_byte are registered: one cycle after the accepting edge (or after the PAD cycle).
- IDLE→STREAM takes 1 cycle. The first ready is the cycle after the grant decision.
- After the last transfer there is 1 cycle to PAD/WAIT_DONE. Ready drops in the same cycle as the state change.
- From pkt_done to the next possible ready: IFG_CYCLES + 2 cycles.
- Counter width: 11 bits, compared against MAX_PAYLOAD ≤ 2047.

## Configuration
- FRAME_SCHED_PAD_EN
  - Defined: short payloads are padded up to MIN_PAYLOAD with PAD_BYTE via the PAD state.
  - Undefined: the PAD state and MIN_PAYLOAD comparator are absent; short frames go directly to WAIT_DONE.

## Structure
- A shared package eth_pkg holds:
  - the state enum typedef,
  - the default MAX_PAYLOAD / MIN_PAYLOAD / IFG_CYCLES localparams,
  - the preamble/SFD constants shared with the packager.
- One natural sub-module is rr_arbiter_2: 2-way round-robin with a pointer register and update-on-grant.
- Counters and the FSM stay in the top level.

## Test plan
- s0 sends 100 bytes with last on byte 100, then pkt_done.
  - Required: 100 pkt_valid strobes with data matching.
  - s0_ready low from the cycle after the last transfer.
  - frames_sent=1.
  - busy low IFG_CYCLES+1 cycles after pkt_done.
- s0 and s1 are both valid continuously with 10-byte messages, over 4 frames.
  - Required: grant sequence 0,1,0,1; the idle source's ready is never high.
- s1 sends a 3200-byte message.
  - Required: three frames of 1500, 1500 and 200 bytes.
  - s1 is re-granted even with s0 valid.
  - s0 is granted only after the 200-byte frame.
- With FRAME_SCHED_PAD_EN, s0 sends a 10-byte message.
  - Required: 10 data bytes, then 36 bytes of 8'h00, for 46 strobes total.
  - Without the macro: exactly 10 strobes.
- pkt_done is pulsed during STREAM and during GAP.
  - Required: frames_sent unchanged, state unaffected.
- rst_n is asserted low at byte 50 of a frame.
  - Required: all outputs 0 asynchronously.
  - After release, s0 has priority and a new frame starts from byte count 0.
